// File: rtl/birthdate_pkg.sv
// birthdate_pkg: shared digit type, checker state encoding and the target digit string 9,2,1,2,1,2
package birthdate_pkg;
  typedef logic [3:0] digit_t;
  typedef enum logic [2:0] {S0, S9, S92, S921, S9212, S92121} chk_state_t;
  localparam int BIRTHDATE_LEN = 6;
  localparam digit_t BIRTHDATE_SEQ [BIRTHDATE_LEN] = '{4'd9, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
  function automatic digit_t expected_digit(input chk_state_t s);
    return BIRTHDATE_SEQ[s];
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: WIDTH-bit up counter (clk, reset active-low async, clr sync, inc) holding at all-ones on cnt
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/birthdate_checker.sv
// birthdate_checker: detects 9,2,1,2,1,2 on valid-qualified digit (clk, reset active-low async, clear, in_valid, digit -> match pulse, saturating match_cnt, progress, bcd_err when BIRTHDATE_CHECKER_BCD_ERR_EN is defined)
import birthdate_pkg::*;
module birthdate_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [3:0]       digit,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [2:0]       progress,
  output logic             bcd_err
);
  chk_state_t state, state_n;
  logic step, hit, last, bad, match_n;
`ifdef BIRTHDATE_CHECKER_BCD_ERR_EN
  assign bad = digit > 4'd9;
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    step = in_valid && !clear;
    hit = digit == expected_digit(state);
    last = state == S92121;
    match_n = step && hit && last;
    state_n = clear ? S0 : !in_valid ? state : bad ? S0 :
              hit ? (last ? S0 : chk_state_t'(state + 3'd1)) :
              digit == 4'd9 ? S9 : S0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S0;
      match <= 1'b0;
    end else begin
      state <= state_n;
      match <= match_n;
    end
`ifdef BIRTHDATE_CHECKER_BCD_ERR_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) bcd_err <= 1'b0;
    else bcd_err <= step && bad;
`else
  assign bcd_err = 1'b0;
`endif
  assign progress = state;
  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(clear),
    .inc(match_n),
    .cnt(match_cnt)
  );
endmodule

// File: tb/tb_birthdate_checker.sv
// tb_birthdate_checker: scoreboard bench for birthdate_checker with default and 2-bit counter instances
module tb_birthdate_checker;
  typedef struct {bit err; int cnt;} ev_t;
  logic clk = 1'b0;
  logic reset, clear, in_valid;
  logic [3:0] digit;
  logic match, bcd_err, match2, err2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic [2:0] prog, prog2;
  int errors = 0;
  int checks = 0;
  ev_t sb[$];
  logic [3:0] sq [6] = '{4'd9, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
  always #5 clk = ~clk;
  birthdate_checker dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .digit(digit),
    .match(match), .match_cnt(cnt), .progress(prog), .bcd_err(bcd_err)
  );
  birthdate_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .digit(digit),
    .match(match2), .match_cnt(cnt2), .progress(prog2), .bcd_err(err2)
  );
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  always @(negedge clk)
    if (reset && (match || bcd_err)) begin
      if (sb.size() == 0) chk("unexpected_pulse", {match, bcd_err}, 0);
      else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_match", match, !e.err);
        chk("ev_bcd_err", bcd_err, e.err);
        chk("ev_cnt", cnt, e.cnt);
      end
    end
  task automatic expm(input int c);
    sb.push_back('{err: 1'b0, cnt: c});
  endtask
  task automatic dig(input logic [3:0] d, input int p);
    in_valid = 1'b1;
    digit = d;
    @(negedge clk);
    chk("progress", prog, p);
  endtask
  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic full(input int g);
    for (int i = 0; i < 6; i++) begin
      dig(sq[i], (i + 1) % 6);
      if (g > 0) gap(g);
    end
  endtask
  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; digit = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_match", match, 0); chk("rst_cnt", cnt, 0); chk("rst_prog", prog, 0);
    chk("rst_err", bcd_err, 0); chk("rst2_all", {match2, cnt2, prog2, err2}, 0);
    reset = 1'b1;
    expm(1); full(0); gap(1);
    chk("t1_cnt", cnt, 1); chk("t1_match_low", match, 0);
    expm(2); dig(4'd9, 1); full(0); gap(1);
    chk("t2_cnt", cnt, 2);
    dig(4'd9, 1); dig(4'd2, 2); dig(4'd1, 3); dig(4'd2, 4); dig(4'd1, 5); dig(4'd3, 0); gap(1);
    chk("t3_cnt", cnt, 2);
    expm(3); full(1); expm(4); full(1);
    chk("t4_cnt", cnt, 4); chk("t4_cnt2", cnt2, 3);
    dig(4'd9, 1);
    clear = 1'b1; in_valid = 1'b1; digit = 4'd2;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_prog", prog, 0); chk("clr_cnt", cnt, 0); chk("clr_cnt2", cnt2, 0);
    for (int k = 1; k <= 5; k++) begin
      expm(k); full(0);
      chk("sat_cnt2", cnt2, k > 3 ? 3 : k);
    end
    gap(1);
    chk("sat_cnt", cnt, 5);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr2_cnt2", cnt2, 0); chk("clr2_prog2", prog2, 0); chk("clr2_cnt", cnt, 0);
    expm(1); full(0);
    dig(4'd9, 1); dig(4'd2, 2); dig(4'd1, 3);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk("async_prog", prog, 0); chk("async_cnt", cnt, 0); chk("async_match", match, 0);
    @(negedge clk);
    reset = 1'b1;
    dig(4'd2, 0); dig(4'd1, 0); dig(4'd2, 0); gap(1);
    chk("post_rst_cnt", cnt, 0);
    dig(4'd9, 1); dig(4'd2, 2);
`ifdef BIRTHDATE_CHECKER_BCD_ERR_EN
    sb.push_back('{err: 1'b1, cnt: 0});
`endif
    dig(4'd10, 0); dig(4'd1, 0); dig(4'd2, 0); dig(4'd1, 0); dig(4'd2, 0); gap(2);
    chk("bcd_cnt", cnt, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/birthdate_checker.md
Name: birthdate_checker

Overview:
- Sequence detector and consumer for the 4-bit digit stream produced by the team's birthdate sequence generators.
- Watches a valid-qualified digit input and recognises the fixed digit string 9,2,1,2,1,2.
- Reports each complete match as a one-cycle pulse, keeps a saturating match count, and exposes its progress through the string.
- Sits on the far side of a generator, typically in a self-checking harness or a display front end.

Parameters:
- CNT_W, 8, width of the saturating match counter (minimum 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserting low immediately clears all state.
- clear  input  1  synchronous clear of FSM state and counter; has priority over in_valid.
- in_valid  input  1  qualifies digit; digit consumed only in a cycle with in_valid=1.
- digit  input  4  BCD digit in (expected 0-9).
- match  output  1  registered pulse, high for exactly one cycle after the final digit of a match is consumed.
- match_cnt  output  CNT_W  number of matches since reset/clear; saturates at all-ones.
- progress  output  3  digits of the string currently matched (0-5).
- bcd_err  output  1  registered pulse on a non-BCD digit (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state=S0, match=0, match_cnt=0, progress=0, bcd_err=0.
- FSM states: S0 (none matched), S9, S92, S921, S9212, S92121. progress is 0 through 5 respectively and is driven directly from state.
- Transitions apply only when in_valid=1 and clear=0. Otherwise all state holds and match/bcd_err are 0 next cycle.
- Expected next digit per state:
  - S0 expects 9.
  - S9 expects 2.
  - S92 expects 1.
  - S921 expects 2.
  - S9212 expects 1.
  - S92121 expects 2.
- Expected digit received: advance one state. From S92121, a 2 completes the match: next state S0, match=1 next cycle, match_cnt increments.
- Unexpected digit: next state S9 if digit==9, else S0. This holds in every state, including S9 receiving another 9, which stays in S9.
- The string has no proper prefix equal to a suffix, so no other overlap recovery is needed. Back-to-back strings 921212921212 yield two matches.
- Latency: match rises in the cycle after the clock edge that consumed the final 2.
- match_cnt saturates at 2^CNT_W-1. Further matches still pulse match but the count holds.
- clear=1: next state S0, match_cnt=0, match=0, bcd_err=0, regardless of in_valid.
- Reset asserted mid-string discards partial progress. The first digit after reset release is evaluated from S0.
- in_valid gaps of any length inside a string do not break the match.

Optional Feature:
- Macro: BIRTHDATE_CHECKER_BCD_ERR_EN.
- Defined:
  - A consumed digit in 10..15 sets bcd_err=1 for one cycle and forces the next state to S0.
  - It is never treated as a 9.
  - match_cnt is unaffected.
- Undefined:
  - bcd_err is tied 0.
  - Non-BCD digits follow the ordinary unexpected-digit rule, which also lands in S0.
- The port list is identical in both builds.

Decomposition:
- Shared package birthdate_pkg:
  - digit_t (logic [3:0]).
  - State enum chk_state_t with 3-bit encoding S0=0 … S92121=5.
  - Constant array BIRTHDATE_SEQ = {9,2,1,2,1,2}.
  - Constant BIRTHDATE_LEN = 6.
- One natural sub-module: sat_counter (parameterised WIDTH; inputs inc and clr; saturating output), instantiated for match_cnt.
- FSM and pulse registers stay in birthdate_checker.

Test Plan:
- Reset then feed valid digits 9,2,1,2,1,2 on consecutive cycles: match high for exactly one cycle, one cycle after the last 2; match_cnt=1; progress shows 1,2,3,4,5 then 0.
- Feed 9,9,2,1,2,1,2: the second 9 keeps S9 and the match still fires, so match_cnt=1. Feed 9,2,1,2,1,3: no match, progress returns to 0.
- Feed 921212921212 with in_valid toggling 1,0,1,0 throughout: two match pulses, match_cnt=2.
- CNT_W=2, five full strings: match pulses five times, match_cnt sticks at 3. Then clear=1 for one cycle: match_cnt=0, progress=0.
- Feed 9,2,1 then pull reset low asynchronously between clock edges: outputs clear immediately. After release, feed 2,1,2: no match.
- With BIRTHDATE_CHECKER_BCD_ERR_EN defined, feed 9,2,A,1,2,1,2: bcd_err pulses once, progress drops to 0, no match. Without the macro: bcd_err stays 0, still no match.
